rgbw_mult_scheduler: RTL

//  Shares the single 8x8 multiplier (mult8x8 handshake: ld/a/b -> mult_rdy/result) between the

---
 rtl/rgbw_pkg.sv | 10 +
 rtl/rgbw_rr_arbiter.sv | 26 ++
 rtl/rgbw_mult_scheduler.sv | 84 ++++++++
 3 files changed

// File: rtl/rgbw_pkg.sv
// rgbw_pkg: shared FSM encoding, channel indices and default operand width
// for the RGBW intensity-scaling multiply scheduler.
package rgbw_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_DONE} state_t;
  localparam int CH_RED     = 0;
  localparam int CH_GREEN   = 1;
  localparam int CH_BLUE    = 2;
  localparam int CH_WHITE   = 3;
  localparam int DEFAULT_DW = 8;
endpackage

// File: rtl/rgbw_rr_arbiter.sv
// rgbw_rr_arbiter: combinational round-robin pick, scanning upward from the
// requester just after the last one served and wrapping.
module rgbw_rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    gnt_id,
  output logic             gnt_vld
);
  logic [IW-1:0] idx;
  always_comb begin
    gnt_id = '0;
    gnt_vld = 1'b0;
    idx = '0;
    // Walk from the farthest candidate toward the nearest so the nearest set request wins
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % N_REQ);
      if (req[idx]) begin
        gnt_id = idx;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rgbw_mult_scheduler.sv
// rgbw_mult_scheduler: shares one handshaked 8x8 multiplier between the RGBW
// scaling requesters, round-robin, one multiply in flight, with a ready watchdog.
module rgbw_mult_scheduler
  import rgbw_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = 63,
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] op_a,
  input  logic [N_REQ*DW-1:0] op_b,
  output logic [N_REQ-1:0]    ack,
  output logic [2*DW-1:0]     res,
  output logic                err,
  output logic                busy,
  output logic [IW-1:0]       grant_id,
  output logic                mult_ld,
  output logic [DW-1:0]       mult_a,
  output logic [DW-1:0]       mult_b,
  input  logic                mult_rdy,
  input  logic [2*DW-1:0]     mult_res
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state, nxt;
  logic [IW-1:0] last, gnt_id;
  logic gnt_vld, armed, hit, abort;
  logic [CW-1:0] cnt;

  rgbw_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req),
    .last(last),
    .gnt_id(gnt_id),
    .gnt_vld(gnt_vld)
  );

  // armed is low only in the first WAIT cycle, where a ready left over from the prior op is ignored
  always_comb begin
    hit = state == ST_WAIT && armed && mult_rdy;
    abort = TIMEOUT != 0 && state == ST_WAIT && armed && !mult_rdy && cnt == CW'(TIMEOUT - 1);
    nxt = state == ST_IDLE ? (gnt_vld ? ST_LOAD : ST_IDLE)
        : state == ST_LOAD ? ST_WAIT
        : state == ST_WAIT ? (hit ? ST_DONE : abort ? ST_IDLE : ST_WAIT)
        : ST_IDLE;
    busy = state != ST_IDLE;
    mult_ld = state == ST_LOAD;
    ack = state == ST_DONE && req[grant_id] ? N_REQ'(1) << grant_id : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      last <= IW'(N_REQ - 1);
      grant_id <= '0;
      mult_a <= '0;
      mult_b <= '0;
      res <= '0;
      err <= 1'b0;
      cnt <= '0;
      armed <= 1'b0;
    end else begin
      state <= nxt;
      err <= abort;
      if (state == ST_IDLE && gnt_vld) begin
        grant_id <= gnt_id;
        mult_a <= op_a[gnt_id*DW +: DW];
        mult_b <= op_b[gnt_id*DW +: DW];
      end
      if (state == ST_LOAD) begin
        cnt <= '0;
        armed <= 1'b0;
      end
      if (state == ST_WAIT) begin
        armed <= 1'b1;
        if (armed && !mult_rdy && !(&cnt)) cnt <= cnt + CW'(1);
      end
      if (hit) res <= mult_res;
      if (abort || state == ST_DONE) last <= grant_id;
    end
  end
endmodule
